// File: rtl/exec_pc_alu_unit.sv
// Execute and PC-generation slice of the single-cycle ARM-subset core.
// Holds the PC, forms PC+4/PC+8, extends immediates, runs the ALU and
// latches the NZCV flags. exec_pc_adder is the generic adder used for PC+4/PC+8.

module exec_pc_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Plain modular add, carry out discarded
    assign y = a + b;

endmodule

module exec_pc_alu_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PCSrc,
    input  logic             PCS_ALU_SrcA,
    input  logic             ALUSrc,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       ImmSrc,
    input  logic             FlagWrite,
    input  logic [23:0]      Instr,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] PCPlus8,
    output logic [WIDTH-1:0] ExtImm,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] WriteData
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOrr = 3'b011;
    localparam logic [2:0] OpEor = 3'b100;
    localparam logic [2:0] OpMov = 3'b101;
    localparam logic [2:0] OpBic = 3'b110;
    localparam logic [2:0] OpMvn = 3'b111;

    localparam logic [WIDTH-1:0] Four = WIDTH'(4);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    exec_pc_adder #(.WIDTH(WIDTH)) u_pc_plus4 (
        .a (pc_q),
        .b (Four),
        .y (PCPlus4)
    );

    exec_pc_adder #(.WIDTH(WIDTH)) u_pc_plus8 (
        .a (PCPlus4),
        .b (Four),
        .y (PCPlus8)
    );

    // Immediate extension by instruction format
    always_comb begin
        ExtImm = '0;
        case (ImmSrc)
            2'b00:   ExtImm = {{(WIDTH-8){1'b0}}, Instr[7:0]};
            2'b01:   ExtImm = {{(WIDTH-12){1'b0}}, Instr[11:0]};
            2'b10:   ExtImm = {{(WIDTH-26){Instr[23]}}, Instr[23:0], 2'b00};
            default: ExtImm = '0;
        endcase
    end

    assign src_a     = PCS_ALU_SrcA ? pc_q : RD1;
    assign src_b     = ALUSrc ? ExtImm : RD2;
    assign WriteData = RD2;

    // SUB reuses the adder as a + ~b + 1 so C means "no borrow"
    assign b_eff = (ALUControl == OpSub) ? ~src_b : src_b;
    assign sum   = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (ALUControl == OpSub)};

    // ALU result plus C/V; C and V only meaningful for arithmetic ops
    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OpAnd:   result = src_a & src_b;
            OpOrr:   result = src_a | src_b;
            OpEor:   result = src_a ^ src_b;
            OpMov:   result = src_b;
            OpBic:   result = src_a & ~src_b;
            OpMvn:   result = ~src_b;
            default: result = '0;
        endcase
    end

    assign ALUResult = result;
    assign ALUFlags  = {result[WIDTH-1], (result == '0), carry, overflow};

    assign pc_next = PCSrc ? result : PCPlus4;

    // PC register, enabled by ~Stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (!Stall) begin
            pc_q <= pc_next;
        end
    end

    // Flags register, independent of Stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (FlagWrite) begin
            flags_q <= ALUFlags;
        end
    end

    assign PC    = pc_q;
    assign Flags = flags_q;

endmodule

// File: tb/tb_exec_pc_alu_unit.sv
// Directed self-checking bench for exec_pc_alu_unit.

module tb_exec_pc_alu_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        PCSrc;
    logic        PCS_ALU_SrcA;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        FlagWrite;
    logic [23:0] Instr;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;
    logic [31:0] ExtImm;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;
    logic [3:0]  Flags;
    logic [31:0] WriteData;

    int tests;
    int fails;

    exec_pc_alu_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .PCS_ALU_SrcA (PCS_ALU_SrcA),
        .ALUSrc       (ALUSrc),
        .ALUControl   (ALUControl),
        .ImmSrc       (ImmSrc),
        .FlagWrite    (FlagWrite),
        .Instr        (Instr),
        .RD1          (RD1),
        .RD2          (RD2),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .PCPlus8      (PCPlus8),
        .ExtImm       (ExtImm),
        .ALUResult    (ALUResult),
        .ALUFlags     (ALUFlags),
        .Flags        (Flags),
        .WriteData    (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        tests++;
        if (PC !== 32'h0) begin
            fails++; $display("FAIL reset_pc got %h want %h", PC, 32'h0);
        end
        tests++;
        if (Flags !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want %b", Flags, 4'b0000);
        end
        tests++;
        if (PCPlus4 !== 32'h4) begin
            fails++; $display("FAIL reset_pcplus4 got %h want %h", PCPlus4, 32'h4);
        end
        tests++;
        if (PCPlus8 !== 32'h8) begin
            fails++; $display("FAIL reset_pcplus8 got %h want %h", PCPlus8, 32'h8);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_pc_increment();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4;
        exp_pc[1] = 32'h8;
        exp_pc[2] = 32'hC;
        do_reset();
        Stall = 1'b0;
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (PC !== exp_pc[i]) begin
                fails++; $display("FAIL pc_inc_%0d got %h want %h", i, PC, exp_pc[i]);
            end
        end
        tests++;
        if (PCPlus8 !== 32'h14) begin
            fails++; $display("FAIL pcplus8_at_c got %h want %h", PCPlus8, 32'h14);
        end
    endtask

    task automatic test_stall_branch();
        do_reset();
        Stall = 1'b0;
        PCSrc = 1'b0;
        step();
        step();
        tests++;
        if (PC !== 32'h8) begin
            fails++; $display("FAIL stall_pre_pc got %h want %h", PC, 32'h8);
        end
        // Stall wins over a taken branch
        Stall        = 1'b1;
        PCSrc        = 1'b1;
        PCS_ALU_SrcA = 1'b1;
        ImmSrc       = 2'b10;
        Instr        = 24'hFFFFFE;
        ALUSrc       = 1'b1;
        ALUControl   = 3'b000;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (PC !== 32'h8) begin
                fails++; $display("FAIL stall_hold_%0d got %h want %h", i, PC, 32'h8);
            end
        end
        tests++;
        if (ExtImm !== 32'hFFFFFFF8) begin
            fails++; $display("FAIL branch_extimm got %h want %h", ExtImm, 32'hFFFFFFF8);
        end
        tests++;
        if (ALUResult !== 32'h0) begin
            fails++; $display("FAIL branch_result got %h want %h", ALUResult, 32'h0);
        end
        tests++;
        if (ALUFlags !== 4'b0110) begin
            fails++; $display("FAIL branch_flags got %b want %b", ALUFlags, 4'b0110);
        end
        Stall = 1'b0;
        step();
        tests++;
        if (PC !== 32'h0) begin
            fails++; $display("FAIL branch_taken_pc got %h want %h", PC, 32'h0);
        end
        PCSrc        = 1'b0;
        PCS_ALU_SrcA = 1'b0;
    endtask

    task automatic test_add_overflow();
        Stall      = 1'b1;
        ALUSrc     = 1'b0;
        ALUControl = 3'b000;
        RD1        = 32'h7FFFFFFF;
        RD2        = 32'h00000001;
        FlagWrite  = 1'b0;
        #1;
        tests++;
        if (ALUResult !== 32'h80000000) begin
            fails++; $display("FAIL add_ovf_result got %h want %h", ALUResult, 32'h80000000);
        end
        tests++;
        if (ALUFlags !== 4'b1001) begin
            fails++; $display("FAIL add_ovf_aluflags got %b want %b", ALUFlags, 4'b1001);
        end
        tests++;
        if (WriteData !== 32'h1) begin
            fails++; $display("FAIL writedata got %h want %h", WriteData, 32'h1);
        end
        tests++;
        if (Flags !== 4'b0000) begin
            fails++; $display("FAIL flags_unwritten got %b want %b", Flags, 4'b0000);
        end
        // FlagWrite must still act while stalled
        FlagWrite = 1'b1;
        step();
        FlagWrite = 1'b0;
        tests++;
        if (Flags !== 4'b1001) begin
            fails++; $display("FAIL flags_latched got %b want %b", Flags, 4'b1001);
        end
        Stall = 1'b0;
    endtask

    task automatic test_sub();
        ALUSrc     = 1'b0;
        ALUControl = 3'b001;
        FlagWrite  = 1'b0;
        RD1        = 32'd5;
        RD2        = 32'd5;
        #1;
        tests++;
        if (ALUResult !== 32'h0) begin
            fails++; $display("FAIL sub_eq_result got %h want %h", ALUResult, 32'h0);
        end
        tests++;
        if (ALUFlags !== 4'b0110) begin
            fails++; $display("FAIL sub_eq_flags got %b want %b", ALUFlags, 4'b0110);
        end
        step();
        tests++;
        if (Flags !== 4'b1001) begin
            fails++; $display("FAIL flags_hold got %b want %b", Flags, 4'b1001);
        end
        RD1 = 32'd3;
        RD2 = 32'd5;
        #1;
        tests++;
        if (ALUResult !== 32'hFFFFFFFE) begin
            fails++; $display("FAIL sub_neg_result got %h want %h", ALUResult, 32'hFFFFFFFE);
        end
        tests++;
        if (ALUFlags !== 4'b1000) begin
            fails++; $display("FAIL sub_neg_flags got %b want %b", ALUFlags, 4'b1000);
        end
    endtask

    task automatic test_logic();
        logic [2:0]  ops   [8];
        logic [1:0]  imms  [8];
        logic [31:0] exts  [8];
        logic [31:0] res   [8];
        logic [3:0]  flg   [8];
        ops[0] = 3'b010; imms[0] = 2'b00; exts[0] = 32'h000000BC; res[0] = 32'h000000B0; flg[0] = 4'b0000;
        ops[1] = 3'b010; imms[1] = 2'b01; exts[1] = 32'h00000ABC; res[1] = 32'h000000B0; flg[1] = 4'b0000;
        ops[2] = 3'b011; imms[2] = 2'b00; exts[2] = 32'h000000BC; res[2] = 32'hF0F0F0FC; flg[2] = 4'b1000;
        ops[3] = 3'b100; imms[3] = 2'b00; exts[3] = 32'h000000BC; res[3] = 32'hF0F0F04C; flg[3] = 4'b1000;
        ops[4] = 3'b110; imms[4] = 2'b00; exts[4] = 32'h000000BC; res[4] = 32'hF0F0F040; flg[4] = 4'b1000;
        ops[5] = 3'b111; imms[5] = 2'b00; exts[5] = 32'h000000BC; res[5] = 32'hFFFFFF43; flg[5] = 4'b1000;
        ops[6] = 3'b101; imms[6] = 2'b01; exts[6] = 32'h00000ABC; res[6] = 32'h00000ABC; flg[6] = 4'b0000;
        ops[7] = 3'b101; imms[7] = 2'b11; exts[7] = 32'h00000000; res[7] = 32'h00000000; flg[7] = 4'b0100;
        ALUSrc = 1'b1;
        RD1    = 32'hF0F0F0F0;
        RD2    = 32'h12345678;
        Instr  = 24'h000ABC;
        for (int i = 0; i < 8; i++) begin
            ALUControl = ops[i];
            ImmSrc     = imms[i];
            #1;
            tests++;
            if (ExtImm !== exts[i]) begin
                fails++; $display("FAIL logic_ext_%0d got %h want %h", i, ExtImm, exts[i]);
            end
            tests++;
            if (ALUResult !== res[i]) begin
                fails++; $display("FAIL logic_res_%0d got %h want %h", i, ALUResult, res[i]);
            end
            tests++;
            if (ALUFlags !== flg[i]) begin
                fails++; $display("FAIL logic_flags_%0d got %b want %b", i, ALUFlags, flg[i]);
            end
        end
        ALUSrc = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        Stall      = 1'b0;
        PCSrc      = 1'b0;
        ALUSrc     = 1'b0;
        ALUControl = 3'b000;
        RD1        = 32'h7FFFFFFF;
        RD2        = 32'h00000001;
        FlagWrite  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        FlagWrite = 1'b0;
        tests++;
        if (PC !== 32'h10) begin
            fails++; $display("FAIL async_pre_pc got %h want %h", PC, 32'h10);
        end
        tests++;
        if (Flags !== 4'b1001) begin
            fails++; $display("FAIL async_pre_flags got %b want %b", Flags, 4'b1001);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (PC !== 32'h0) begin
            fails++; $display("FAIL async_pc got %h want %h", PC, 32'h0);
        end
        tests++;
        if (Flags !== 4'b0000) begin
            fails++; $display("FAIL async_flags got %b want %b", Flags, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        Stall        = 1'b0;
        PCSrc        = 1'b0;
        PCS_ALU_SrcA = 1'b0;
        ALUSrc       = 1'b0;
        ALUControl   = 3'b000;
        ImmSrc       = 2'b00;
        FlagWrite    = 1'b0;
        Instr        = 24'h0;
        RD1          = 32'h0;
        RD2          = 32'h0;
        test_reset();
        test_pc_increment();
        test_stall_branch();
        test_add_overflow();
        test_sub();
        test_logic();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_pc_alu_unit.md
Name: exec_pc_alu_unit

Overview:
Execute and PC-generation slice of the single-cycle ARM-subset core.
- Holds the program counter and derives PC+4 and PC+8 using two instances of a generic adder.
- Extends instruction immediates, selects ALU operands, computes the ALU result and NZCV flags, and latches those flags.
- Register file, instruction/data memory and control decode sit outside this block.

Parameters:
WIDTH, 32, datapath width for the adder, ALU and PC; only 32 must be supported.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Stall  in  1  1 = hold PC (PC register enable is ~Stall)
PCSrc  in  1  next-PC select: 0 = PCPlus4, 1 = ALUResult
PCS_ALU_SrcA  in  1  ALU A select: 0 = RD1, 1 = PC
ALUSrc  in  1  ALU B select: 0 = RD2, 1 = ExtImm
ALUControl  in  3  ALU operation
ImmSrc  in  2  immediate format
FlagWrite  in  1  1 = latch ALUFlags into Flags on the clock edge
Instr  in  24  instruction bits [23:0]
RD1  in  32  register-file read port 1
RD2  in  32  register-file read port 2
PC  out  32  current program counter (registered)
PCPlus4  out  32  PC + 4
PCPlus8  out  32  PC + 8, fed to register-file r15
ExtImm  out  32  extended immediate
ALUResult  out  32  ALU result
ALUFlags  out  4  combinational {N,Z,C,V}
Flags  out  4  registered {N,Z,C,V}
WriteData  out  32  equals RD2

Behaviour:
Reset and registers:
- reset high asynchronously forces PC = 0 and Flags = 0.
- All other outputs are combinational.
- PC: on the rising edge, if ~Stall, PC <= PCNext; otherwise PC holds.
- PCNext = PCSrc ? ALUResult : PCPlus4.
- Flags: on the rising edge, if FlagWrite, Flags <= ALUFlags; otherwise Flags holds.
- Stall does not gate FlagWrite.

PC adders:
- PCPlus4 = PC + 4 and PCPlus8 = PCPlus4 + 4, each mod 2^32 (wraps).
- Each is an instance of a combinational adder module: inputs a, b and output y, all WIDTH bits, no carry out.

Extend unit (combinational):
- ImmSrc 00: zero-extend Instr[7:0].
- ImmSrc 01: zero-extend Instr[11:0].
- ImmSrc 10: {{6{Instr[23]}}, Instr[23:0], 2'b00} (branch offset).
- ImmSrc 11: 0.

Operand select:
- SrcA = PCS_ALU_SrcA ? PC : RD1.
- SrcB = ALUSrc ? ExtImm : RD2.

ALU operations (ALUControl):
- 000 ADD a+b
- 001 SUB a-b (computed as a+~b+1)
- 010 AND
- 011 ORR
- 100 EOR
- 101 MOV: pass b
- 110 BIC: a & ~b
- 111 MVN: ~b

ALU flags:
- N = Result[31]; Z = (Result == 0).
- ADD/SUB: C = carry out of the 33-bit sum; for SUB, C = 1 means no borrow. V = the operands' signs (after inverting b for SUB) match each other and differ from the result's sign.
- Logical ops and MOV/MVN: C = 0, V = 0.

Simultaneous events:
- Stall with PCSrc = 1: PC still holds.
- reset asserted mid-cycle clears PC and Flags immediately, independent of clk.

Test Plan:
- Reset, then 3 edges with Stall=0, PCSrc=0 -> PC = 0, 4, 8, 0xC; PCPlus8 = 0x14 at PC = 0xC.
- PC = 8, Stall=1 for 2 edges -> PC stays 8; then Stall=0, PCSrc=1, PCS_ALU_SrcA=1, ImmSrc=10, Instr=0xFFFFFE, ALUSrc=1, ADD -> ExtImm = 0xFFFFFFF8, ALUResult = 0, next PC = 0.
- RD1=0x7FFFFFFF, RD2=1, ADD, FlagWrite=1 -> ALUResult = 0x80000000, ALUFlags = 1001, Flags = 1001 after the edge.
- RD1=5, RD2=5, SUB -> ALUResult = 0, ALUFlags = 0110; RD1=3, RD2=5, SUB -> 0xFFFFFFFE, flags 1000.
- ImmSrc 00/01 with Instr=0x000ABC, ALUSrc=1, RD1=0xF0F0F0F0: AND -> 0xB0 / 0x0B0; ORR, EOR, BIC, MVN each match their formula with C=V=0.
- Assert reset asynchronously between edges at PC = 0x10, Flags = 1001 -> PC = 0 and Flags = 0 immediately, without a clock edge.
